// File: rtl/sap_cpu_param.sv
// sap_cpu_param: width-parametrised SAP-style accumulator CPU with a program-load port.
// Optional single-step control is compiled in with `define SAP_CPU_STEP_EN.
module sap_cpu_param #(
    parameter int unsigned DATA_W = 8,
    parameter int unsigned ADDR_W = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load_en,
    input  logic [ADDR_W-1:0] load_addr,
    input  logic [DATA_W-1:0] load_data,
    input  logic              start,
`ifdef SAP_CPU_STEP_EN
    input  logic              step_mode,
    input  logic              step,
`endif
    output logic [DATA_W-1:0] out_data,
    output logic              out_valid,
    output logic              halted,
    output logic              carry,
    output logic              zero,
    output logic [ADDR_W-1:0] pc_dbg
);

    localparam int unsigned DEPTH = 2 ** ADDR_W;
    localparam int unsigned OP_W  = 4;
    localparam int unsigned SUM_W = DATA_W + 1;

    localparam logic [OP_W-1:0] OP_LDA = 4'h1;
    localparam logic [OP_W-1:0] OP_ADD = 4'h2;
    localparam logic [OP_W-1:0] OP_SUB = 4'h3;
    localparam logic [OP_W-1:0] OP_STA = 4'h4;
    localparam logic [OP_W-1:0] OP_LDI = 4'h5;
    localparam logic [OP_W-1:0] OP_JMP = 4'h6;
    localparam logic [OP_W-1:0] OP_JC  = 4'h7;
    localparam logic [OP_W-1:0] OP_JZ  = 4'h8;
    localparam logic [OP_W-1:0] OP_OUT = 4'hE;
    localparam logic [OP_W-1:0] OP_HLT = 4'hF;

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_F0   = 3'd1,
        S_F1   = 3'd2,
        S_F2   = 3'd3,
        S_E0   = 3'd4,
        S_E1   = 3'd5,
        S_E2   = 3'd6
    } state_t;

    state_t state;
    state_t state_nxt;

    logic [ADDR_W-1:0] pc;
    logic [ADDR_W-1:0] mar;
    logic [DATA_W-1:0] acc;
    logic [DATA_W-1:0] ir;
    logic [DATA_W-1:0] mem_q;
    logic [DATA_W-1:0] mem [DEPTH];

    logic [OP_W-1:0]   opcode;
    logic [ADDR_W-1:0] operand;
    logic              mem_op_c;
    logic              f0_go_c;

    logic              pc_clr_c;
    logic              pc_inc_c;
    logic              pc_jmp_c;
    logic              mar_pc_c;
    logic              mar_opd_c;
    logic              ir_ld_c;
    logic              acc_ldi_c;
    logic              acc_mem_c;
    logic              acc_add_c;
    logic              acc_sub_c;
    logic              out_ld_c;
    logic              mem_we_c;
    logic [ADDR_W-1:0] wr_addr_c;
    logic [DATA_W-1:0] wr_data_c;

    logic [SUM_W-1:0]  sum_c;
    logic [SUM_W-1:0]  diff_c;

    assign opcode   = ir[DATA_W-1 -: OP_W];
    assign operand  = ir[ADDR_W-1:0];
    assign mem_op_c = (opcode == OP_LDA) || (opcode == OP_ADD) ||
                      (opcode == OP_SUB) || (opcode == OP_STA);
    assign pc_dbg   = pc;

`ifdef SAP_CPU_STEP_EN
    assign f0_go_c = !step_mode || step;
`else
    assign f0_go_c = 1'b1;
`endif

    // Subtraction is acc + ~b + 1 so the carry-out reads as "no borrow".
    assign sum_c  = {1'b0, acc} + {1'b0, mem_q};
    assign diff_c = {1'b0, acc} + {1'b0, ~mem_q} + SUM_W'(1);

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: if (start) state_nxt = S_F0;
            S_F0:   if (f0_go_c) state_nxt = S_F1;
            S_F1:   state_nxt = S_F2;
            S_F2:   state_nxt = S_E0;
            S_E0: begin
                if (mem_op_c)              state_nxt = S_E1;
                else if (opcode == OP_HLT) state_nxt = S_IDLE;
                else                       state_nxt = S_F0;
            end
            S_E1:   state_nxt = (opcode == OP_STA) ? S_F0 : S_E2;
            S_E2:   state_nxt = S_F0;
            default: state_nxt = S_IDLE;
        endcase
    end

    // Datapath control decode
    always_comb begin
        pc_clr_c  = 1'b0;
        pc_inc_c  = 1'b0;
        pc_jmp_c  = 1'b0;
        mar_pc_c  = 1'b0;
        mar_opd_c = 1'b0;
        ir_ld_c   = 1'b0;
        acc_ldi_c = 1'b0;
        acc_mem_c = 1'b0;
        acc_add_c = 1'b0;
        acc_sub_c = 1'b0;
        out_ld_c  = 1'b0;
        mem_we_c  = 1'b0;
        wr_addr_c = '0;
        wr_data_c = '0;
        case (state)
            S_IDLE: begin
                pc_clr_c  = start;
                mem_we_c  = load_en && !rst;
                wr_addr_c = load_addr;
                wr_data_c = load_data;
            end
            S_F0: mar_pc_c = 1'b1;
            S_F1: pc_inc_c = 1'b1;
            S_F2: ir_ld_c  = 1'b1;
            S_E0: begin
                mar_opd_c = mem_op_c;
                acc_ldi_c = (opcode == OP_LDI);
                out_ld_c  = (opcode == OP_OUT);
                pc_jmp_c  = (opcode == OP_JMP) ||
                            ((opcode == OP_JC) && carry) ||
                            ((opcode == OP_JZ) && zero);
            end
            S_E1: begin
                // rst gating keeps an aborted STA from landing in memory.
                mem_we_c  = (opcode == OP_STA) && !rst;
                wr_addr_c = mar;
                wr_data_c = acc;
            end
            S_E2: begin
                acc_mem_c = (opcode == OP_LDA);
                acc_add_c = (opcode == OP_ADD);
                acc_sub_c = (opcode == OP_SUB);
            end
            default: ;
        endcase
    end

    // Architectural registers and outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc        <= '0;
            mar       <= '0;
            ir        <= '0;
            acc       <= '0;
            carry     <= 1'b0;
            zero      <= 1'b0;
            out_data  <= '0;
            out_valid <= 1'b0;
            halted    <= 1'b1;
        end else begin
            out_valid <= out_ld_c;
            halted    <= (state_nxt == S_IDLE);

            if (pc_clr_c)      pc <= '0;
            else if (pc_inc_c) pc <= pc + ADDR_W'(1);
            else if (pc_jmp_c) pc <= operand;

            if (mar_pc_c)       mar <= pc;
            else if (mar_opd_c) mar <= operand;

            if (ir_ld_c) ir <= mem_q;

            if (acc_ldi_c) begin
                acc  <= DATA_W'(operand);
                zero <= (operand == '0);
            end
            if (acc_mem_c) begin
                acc  <= mem_q;
                zero <= (mem_q == '0);
            end
            if (acc_add_c) begin
                {carry, acc} <= sum_c;
                zero         <= (sum_c[DATA_W-1:0] == '0);
            end
            if (acc_sub_c) begin
                {carry, acc} <= diff_c;
                zero         <= (diff_c[DATA_W-1:0] == '0);
            end

            if (out_ld_c) out_data <= acc;
        end
    end

    // Unified memory: synchronous write, registered read
    always_ff @(posedge clk) begin
        if (mem_we_c) mem[wr_addr_c] <= wr_data_c;
        mem_q <= mem[mar];
    end

endmodule

// File: tb/tb_sap_cpu_param.sv
// tb_sap_cpu_param: instruction-level reference model expanded to a per-cycle
// expected trace, compared against sap_cpu_param every cycle of each run.
module tb_sap_cpu_param;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       load_en = 1'b0;
    logic [3:0] load_addr = '0;
    logic [7:0] load_data = '0;
    logic       start = 1'b0;
`ifdef SAP_CPU_STEP_EN
    logic       step_mode = 1'b0;
    logic       step = 1'b0;
`endif
    logic [7:0] out_data;
    logic       out_valid;
    logic       halted;
    logic       carry;
    logic       zero;
    logic [3:0] pc_dbg;

    sap_cpu_param #(.DATA_W(8), .ADDR_W(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .load_en   (load_en),
        .load_addr (load_addr),
        .load_data (load_data),
        .start     (start),
`ifdef SAP_CPU_STEP_EN
        .step_mode (step_mode),
        .step      (step),
`endif
        .out_data  (out_data),
        .out_valid (out_valid),
        .halted    (halted),
        .carry     (carry),
        .zero      (zero),
        .pc_dbg    (pc_dbg)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [3:0] pc;
        logic [7:0] od;
        logic       ov;
        logic       c;
        logic       z;
        logic       h;
    } exp_t;

    exp_t       exp_q[$];
    exp_t       cur;
    logic [7:0] m [16];
    logic [7:0] m_acc = '0;
    logic [7:0] m_out = '0;
    logic       m_c = 1'b0;
    logic       m_z = 1'b0;
    logic       cmp_en = 1'b0;
    int         n_chk = 0;
    int         n_pass = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp_v);
        n_chk++;
        if (act === exp_v) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp_v, $time);
    endtask

    task automatic push(input int pc, input bit ov, input bit h);
        exp_t e;
        e.pc = 4'(pc);
        e.od = m_out;
        e.ov = ov;
        e.c  = m_c;
        e.z  = m_z;
        e.h  = h;
        exp_q.push_back(e);
    endtask

    // Run the ISA from pc=0 on the model memory and expand it into cycles.
    task automatic build(input int budget);
        int pc, n, op, opd, len, seq, npc, a, b, s;
        bit ov, done;
        logic [7:0] ins;
        pc = 0; n = 0; ov = 1'b0; done = 1'b0;
        exp_q.delete();
        while (!done && n < budget) begin
            ins = m[pc];
            op  = int'(ins[7:4]);
            opd = int'(ins[3:0]);
            len = (op >= 1 && op <= 3) ? 6 : (op == 4) ? 5 : 4;
            seq = (pc + 1) % 16;
            for (int k = 0; k < len; k++) push((k < 2) ? pc : seq, (k == 0) && ov, 1'b0);
            n  += len;
            ov  = 1'b0;
            npc = seq;
            a   = int'(m_acc);
            b   = int'(m[opd]);
            case (op)
                1: begin m_acc = m[opd]; m_z = (m_acc == 0); end
                2: begin s = a + b; m_c = (s > 255); m_acc = 8'(s); m_z = (m_acc == 0); end
                3: begin s = a - b; m_c = (a >= b); m_acc = 8'(s); m_z = (m_acc == 0); end
                4: m[opd] = m_acc;
                5: begin m_acc = 8'(opd); m_z = (opd == 0); end
                6: npc = opd;
                7: if (m_c) npc = opd;
                8: if (m_z) npc = opd;
                14: begin m_out = m_acc; ov = 1'b1; end
                15: done = 1'b1;
                default: ;
            endcase
            pc = npc;
        end
        if (done) for (int k = 0; k < 3; k++) push(pc, 1'b0, 1'b1);
    endtask

    function automatic int active_len();
        int cnt = 0;
        foreach (exp_q[i]) if (!exp_q[i].h) cnt++;
        return cnt;
    endfunction

    // Per-cycle comparison against the expected trace
    always @(negedge clk) begin
        if (cmp_en && exp_q.size() > 0) begin
            cur = exp_q.pop_front();
            chk("pc_dbg",    32'(pc_dbg),    32'(cur.pc));
            chk("out_data",  32'(out_data),  32'(cur.od));
            chk("out_valid", 32'(out_valid), 32'(cur.ov));
            chk("carry",     32'(carry),     32'(cur.c));
            chk("zero",      32'(zero),      32'(cur.z));
            chk("halted",    32'(halted),    32'(cur.h));
        end
    end

    task automatic load(input int a, input logic [7:0] d);
        @(posedge clk); #1;
        load_en = 1'b1; load_addr = 4'(a); load_data = d;
        m[a] = d;
        @(posedge clk); #1;
        load_en = 1'b0;
    endtask

    task automatic reset_dut();
        @(posedge clk); #1 rst = 1'b1;
        @(posedge clk); #1 rst = 1'b0;
        m_acc = '0; m_out = '0; m_c = 1'b0; m_z = 1'b0;
    endtask

    task automatic run_trace(input int budget);
        @(posedge clk); #1 start = 1'b1;
        @(posedge clk); #1 start = 1'b0; cmp_en = 1'b1;
        for (int i = 0; i < budget + 20; i++) begin
            if (exp_q.size() == 0) break;
            @(posedge clk);
        end
        #1;
        if (exp_q.size() != 0) begin
            chk("trace_timeout", 32'(exp_q.size()), 32'd0);
            exp_q.delete();
        end
        cmp_en = 1'b0;
    endtask

    task automatic run_prog(input int budget);
        build(budget);
        run_trace(budget);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        foreach (m[i]) m[i] = '0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("rst_halted", 32'(halted), 32'd1);
        chk("rst_pc", 32'(pc_dbg), 32'd0);
        chk("rst_out", 32'(out_data), 32'd0);
        chk("rst_valid", 32'(out_valid), 32'd0);
        chk("rst_flags", 32'({carry, zero}), 32'd0);

        // Sum, with loader strobes during the run that must be ignored
        load(0, 8'h19); load(1, 8'h2A); load(2, 8'hE0); load(3, 8'hF0);
        load(9, 8'd28); load(10, 8'd14);
        build(100);
        chk("sum_cycles", 32'(active_len()), 32'd20);
        fork
            run_trace(100);
            begin
                repeat (3) @(posedge clk);
                #1 load_en = 1'b1; load_addr = 4'd9; load_data = 8'h00;
                repeat (10) @(posedge clk);
                #1 load_en = 1'b0;
            end
        join
        chk("sum_out", 32'(out_data), 32'd42);
        chk("sum_flags", 32'({carry, zero}), 32'd0);
        chk("sum_halted", 32'(halted), 32'd1);

        // Subtract with borrow, then to zero
        load(0, 8'h55); load(1, 8'h39); load(2, 8'hE0); load(3, 8'hF0); load(9, 8'd7);
        run_prog(100);
        chk("sub_out", 32'(out_data), 32'hFE);
        chk("sub_flags", 32'({carry, zero}), 32'b00);
        load(0, 8'h57); load(1, 8'h39); load(2, 8'hF0);
        run_prog(100);
        chk("sub0_flags", 32'({carry, zero}), 32'b11);
        chk("sub0_hold", 32'(out_data), 32'hFE);

        // Store and countdown loop, then read the stored word back
        load(0, 8'h53); load(1, 8'h4F); load(2, 8'h1F); load(3, 8'h86);
        load(4, 8'h3E); load(5, 8'h63); load(6, 8'hF0); load(14, 8'h01);
        build(300);
        chk("loop_cycles", 32'(active_len()), 32'd65);
        run_trace(300);
        chk("loop_flags", 32'({carry, zero}), 32'b11);
        load(0, 8'h1F); load(1, 8'hE0); load(2, 8'hF0);
        run_prog(100);
        chk("loop_memF", 32'(out_data), 32'd3);

        // All-NOP memory: PC wraps, never halts
        for (int i = 0; i < 16; i++) load(i, 8'h00);
        run_prog(70);
        chk("wrap_halted", 32'(halted), 32'd0);
        reset_dut();

        // Reset during STA E1: write suppressed, outputs to reset values
        load(0, 8'h55); load(1, 8'hE0); load(2, 8'h49); load(9, 8'h77);
        @(posedge clk); #1 start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        repeat (12) @(posedge clk);
        #1;
        chk("pre_rst_out", 32'(out_data), 32'd5);
        chk("pre_rst_pc", 32'(pc_dbg), 32'd3);
        rst = 1'b1;
        #1;
        chk("mid_rst_halted", 32'(halted), 32'd1);
        chk("mid_rst_pc", 32'(pc_dbg), 32'd0);
        chk("mid_rst_out", 32'(out_data), 32'd0);
        chk("mid_rst_flags", 32'({out_valid, carry, zero}), 32'd0);
        @(posedge clk); #1 rst = 1'b0;
        m_acc = '0; m_out = '0; m_c = 1'b0; m_z = 1'b0;
        load(0, 8'h19); load(1, 8'hE0); load(2, 8'hF0);
        run_prog(100);
        chk("sta_aborted", 32'(out_data), 32'h77);

        // Random programs
        for (int r = 0; r < 8; r++) begin
            for (int i = 0; i < 16; i++) load(i, 8'($urandom));
            run_prog(150);
            reset_dut();
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
